drm_stream_reader: RTL and testbench

- Read-side engine for the single-clock 8-bit x 128-entry simple dual-port DRM buffers.
- Accepts a (start address, length) command and issues sequential reads to the RAM read port, wrapping modulo 2^ADDR_WIDTH.
- Compensates for the RAM's fixed read latency and delivers the words as a valid/ready stream with backpressure, a last flag and a completion pulse.
- Sits between a DRM buffer's read port and downstream packet/DMA logic.

---
 rtl/drm_stream_reader.sv | 192 +++++++++++++++++++
 tb/tb_drm_stream_reader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/drm_stream_reader.sv
// drm_stream_reader: replays a (start, length) command as sequential RAM reads and delivers the words as a valid/ready stream.
// Latency: first beat RD_LATENCY+2 cycles after the command. Backpressure: reads are credit-limited by m_ready, and returns are never dropped.

// drm_fifo: small generic FIFO with a synchronous clear. Latency: one cycle from write to read.
// Backpressure: writes are ignored when full unless a pop occurs in the same cycle.
module drm_fifo #(
   parameter int W     = 9,
   parameter int DEPTH = 3,
   parameter int CW    = 3
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clr_i,
   input  logic          wr_vld_i,
   input  logic [W-1:0]  wr_dat_i,
   output logic          rd_vld_o,
   output logic [W-1:0]  rd_dat_o,
   input  logic          rd_rdy_i,
   output logic [CW-1:0] count_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem_q [2**PW];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          wr, rd;

   assign rd = rd_rdy_i && (count_q != '0);
   assign wr = wr_vld_i && ((count_q != CW'(DEPTH)) || rd);

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int k = 0; k < 2**PW; k++) mem_q[k] <= '0;
      end else if (clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
            wr_ptr_q        <= nxt(wr_ptr_q);
         end
         if (rd) rd_ptr_q <= nxt(rd_ptr_q);
         count_q <= count_q + CW'(wr) - CW'(rd);
      end
   end

   assign rd_vld_o = (count_q != '0);
   assign rd_dat_o = mem_q[rd_ptr_q];
   assign count_o  = count_q;
endmodule

module drm_stream_reader #(
   parameter int ADDR_WIDTH = 7,
   parameter int DATA_WIDTH = 8,
   parameter int RD_LATENCY = 1
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [ADDR_WIDTH:0]   cmd_len,
   input  logic                  flush,
   output logic                  ram_rd_en,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic                  done,
   output logic                  busy
);
   localparam int FIFO_DEPTH = RD_LATENCY + 2;
   localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
   localparam int LW = ADDR_WIDTH + 1;
   localparam logic [LW-1:0] MAX_LEN = LW'(1) << ADDR_WIDTH;

   typedef enum logic [1:0] {IDLE, READ, FIN} state_t;

   state_t                state_q, state_d;
   logic                  cmd_ready_q;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d, rd_addr_q, rd_addr_d;
   logic [LW-1:0]         len_q, len_d, issued_q, issued_d, cmd_len_sat;
   logic                  rd_en_q, rd_en_d, rd_last_q, rd_last_d;
   logic [RD_LATENCY-1:0] ret_vld_q, ret_last_q;
   logic [CW-1:0]         fifo_count, inflight;
   logic                  fifo_vld, pop, credit_ok;
   logic [DATA_WIDTH:0]   fifo_head;

   assign cmd_len_sat = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
   assign pop         = fifo_vld && m_ready;

   // Every read not yet popped holds a FIFO slot; a pop this cycle frees one in time for the new read.
   always_comb begin
      inflight = CW'(rd_en_q);
      for (int k = 0; k < RD_LATENCY; k++) inflight = inflight + CW'(ret_vld_q[k]);
   end
   assign credit_ok = (fifo_count + inflight - CW'(pop)) < CW'(FIFO_DEPTH);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      len_d     = len_q;
      issued_d  = issued_q;
      rd_en_d   = 1'b0;
      rd_last_d = 1'b0;
      rd_addr_d = rd_addr_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (cmd_valid && cmd_ready_q) begin
               len_d    = cmd_len_sat;
               addr_d   = cmd_addr;
               issued_d = '0;
               state_d  = (cmd_len_sat == '0) ? FIN : READ;
            end
            READ:    if (pop && fifo_head[DATA_WIDTH]) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
         endcase
         // Evaluated on next-state values so the first read leaves on the handshake edge.
         if (state_d == READ && issued_d < len_d && credit_ok) begin
            rd_en_d   = 1'b1;
            rd_addr_d = addr_d;
            rd_last_d = (issued_d == len_d - LW'(1));
            addr_d    = addr_d + 1'b1;
            issued_d  = issued_d + LW'(1);
         end
      end
   end

   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b0;
         addr_q      <= '0;
         len_q       <= '0;
         issued_q    <= '0;
         rd_en_q     <= 1'b0;
         rd_last_q   <= 1'b0;
         rd_addr_q   <= '0;
         ret_vld_q   <= '0;
         ret_last_q  <= '0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= (state_d == IDLE);
         addr_q      <= addr_d;
         len_q       <= len_d;
         issued_q    <= issued_d;
         rd_en_q     <= rd_en_d;
         rd_last_q   <= rd_last_d;
         rd_addr_q   <= rd_addr_d;
         ret_vld_q[0]  <= rd_en_q && !flush;
         ret_last_q[0] <= rd_last_q;
         for (int k = 1; k < RD_LATENCY; k++) begin
            ret_vld_q[k]  <= ret_vld_q[k-1] && !flush;
            ret_last_q[k] <= ret_last_q[k-1];
         end
      end
   end

   drm_fifo #(.W(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
      .clk_i    (rd_clk),
      .rst_ni   (rd_rst_n),
      .clr_i    (flush),
      .wr_vld_i (ret_vld_q[RD_LATENCY-1]),
      .wr_dat_i ({ret_last_q[RD_LATENCY-1], ram_rd_data}),
      .rd_vld_o (fifo_vld),
      .rd_dat_o (fifo_head),
      .rd_rdy_i (m_ready),
      .count_o  (fifo_count)
   );

   assign cmd_ready   = cmd_ready_q;
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == FIN);
   assign ram_rd_en   = rd_en_q;
   assign ram_rd_addr = rd_addr_q;
   assign m_valid     = fifo_vld;
   assign m_data      = fifo_head[DATA_WIDTH-1:0];
   assign m_last      = fifo_head[DATA_WIDTH];
endmodule

// File: tb/tb_drm_stream_reader.sv
// Bench: drives one RD_LATENCY=1 and one RD_LATENCY=2 reader with identical stimulus.
// A scoreboard model of each command's address/data sequence is compared by a negedge monitor.
`timescale 1ns/1ps
module tb_drm_stream_reader;
   localparam int AW = 7;
   localparam int DW = 8;
   localparam int LIMIT = 3000;

   logic          rd_clk = 1'b0;
   logic          rd_rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [AW:0]   cmd_len = '0;
   logic          flush = 1'b0;
   logic          m_ready = 1'b0;

   logic          cmd_ready_w [2], ram_rd_en_w [2], m_valid_w [2], m_last_w [2], done_w [2], busy_w [2];
   logic [AW-1:0] ram_rd_addr_w [2];
   logic [DW-1:0] ram_rd_data_w [2], m_data_w [2];
   logic [DW-1:0] mem [128];

   int n_chk = 0, n_fail = 0, cyc = 0;
   bit mon_en = 0, rand_rdy = 0, strict_tp = 0, flush_prev = 0;
   int hs_cyc, cur_len;
   int done_exp [2], done_due [2], first_en_cyc [2], first_beat_cyc [2], outst [2], beats [2];
   bit en_pend [2], val_pend [2], pop_pend [2], prev_stall [2];
   logic [8:0] prev_beat [2];
   logic [8:0] expd0 [$], expd1 [$];
   logic [6:0] expa0 [$], expa1 [$];

   always #5 rd_clk = ~rd_clk;
   always @(posedge rd_clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [DW-1:0] d1, d2;
      logic          v1;
      drm_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(g + 1)) u_dut (
         .rd_clk(rd_clk), .rd_rst_n(rd_rst_n),
         .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_w[g]), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
         .flush(flush),
         .ram_rd_en(ram_rd_en_w[g]), .ram_rd_addr(ram_rd_addr_w[g]), .ram_rd_data(ram_rd_data_w[g]),
         .m_valid(m_valid_w[g]), .m_ready(m_ready), .m_data(m_data_w[g]), .m_last(m_last_w[g]),
         .done(done_w[g]), .busy(busy_w[g])
      );
      // RAM model: output is garbage except exactly RD_LATENCY cycles after a read strobe.
      always @(posedge rd_clk) begin
         d1 <= ram_rd_en_w[g] ? mem[ram_rd_addr_w[g]] : DW'($urandom);
         v1 <= ram_rd_en_w[g];
         d2 <= v1 ? d1 : DW'($urandom);
      end
      assign ram_rd_data_w[g] = (g == 0) ? d1 : d2;
   end

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[lat%0d] @cyc %0d: got 0x%0h, expected 0x%0h", nm, i + 1, cyc, act, exp);
      end
   endtask

   task automatic chk_le(input string nm, input int i, input int act, input int lim);
      n_chk++;
      if (act > lim) begin
         n_fail++;
         $display("FAIL %s[lat%0d] @cyc %0d: got %0d, limit %0d", nm, i + 1, cyc, act, lim);
      end
   endtask

   task automatic mon_inst(input int i);
      int na, nd, lat;
      logic [8:0] e;
      logic [6:0] ea;
      lat = i + 1;
      na = (i == 0) ? expa0.size() : expa1.size();
      nd = (i == 0) ? expd0.size() : expd1.size();
      if (flush_prev) chk("m_valid_after_flush", i, 32'(m_valid_w[i]), 32'd0);
      else if (prev_stall[i]) begin
         chk("stall_valid", i, 32'(m_valid_w[i]), 32'd1);
         chk("stall_data", i, 32'({m_last_w[i], m_data_w[i]}), 32'(prev_beat[i]));
      end
      prev_stall[i] = m_valid_w[i] && !m_ready;
      prev_beat[i]  = {m_last_w[i], m_data_w[i]};
      if (ram_rd_en_w[i]) begin
         if (na == 0) chk("spurious_rd_en", i, 32'(ram_rd_en_w[i]), 32'd0);
         else begin
            ea = (i == 0) ? expa0.pop_front() : expa1.pop_front();
            chk("rd_addr", i, 32'(ram_rd_addr_w[i]), 32'(ea));
            outst[i]++;
            chk_le("outstanding", i, outst[i], lat + 2);
            if (en_pend[i]) begin
               en_pend[i] = 0;
               first_en_cyc[i] = cyc;
               chk("first_rd_en_cycle", i, 32'(cyc), 32'(hs_cyc));
            end
         end
      end
      if (m_valid_w[i] && val_pend[i]) begin
         val_pend[i] = 0;
         chk("first_valid_cycle", i, 32'(cyc), 32'(first_en_cyc[i] + lat + 1));
      end
      if (m_valid_w[i] && m_ready) begin
         beats[i]++;
         outst[i]--;
         if (nd == 0) chk("spurious_beat", i, 32'(m_valid_w[i]), 32'd0);
         else begin
            e = (i == 0) ? expd0.pop_front() : expd1.pop_front();
            chk("beat", i, 32'({m_last_w[i], m_data_w[i]}), 32'(e));
            if (pop_pend[i]) begin
               pop_pend[i] = 0;
               first_beat_cyc[i] = cyc;
            end
            if (e[8]) begin
               done_due[i] = cyc + 1;
               if (strict_tp) chk("no_bubble", i, 32'(cyc), 32'(first_beat_cyc[i] + cur_len - 1));
            end
         end
      end
      if (done_w[i]) begin
         if (done_exp[i] == 0) chk("spurious_done", i, 32'(done_w[i]), 32'd0);
         else begin
            done_exp[i]--;
            chk("done_cycle", i, 32'(cyc), 32'(done_due[i]));
            chk("done_busy", i, 32'(busy_w[i]), 32'd1);
            chk("done_cmd_ready", i, 32'(cmd_ready_w[i]), 32'd0);
         end
      end
   endtask

   always @(negedge rd_clk) begin
      if (mon_en) begin
         for (int i = 0; i < 2; i++) mon_inst(i);
         if (flush) begin
            expd0.delete(); expd1.delete(); expa0.delete(); expa1.delete();
            for (int i = 0; i < 2; i++) begin
               done_exp[i] = 0; outst[i] = 0; en_pend[i] = 0; val_pend[i] = 0; pop_pend[i] = 0;
            end
         end
         flush_prev = flush;
      end
   end

   task automatic issue(input logic [6:0] a, input logic [7:0] len, input bit tp);
      int w, L;
      logic [6:0] ak;
      w = 0;
      while (!(cmd_ready_w[0] && cmd_ready_w[1]) && w < LIMIT) begin
         @(negedge rd_clk);
         w++;
      end
      chk_le("cmd_ready_wait", 0, w, LIMIT - 1);
      @(posedge rd_clk); #1;
      cmd_valid = 1'b1; cmd_addr = a; cmd_len = len; strict_tp = tp;
      @(negedge rd_clk);
      for (int i = 0; i < 2; i++) chk("hs_cmd_ready", i, 32'(cmd_ready_w[i]), 32'd1);
      L = (int'(len) > 128) ? 128 : int'(len);
      cur_len = L;
      hs_cyc = cyc + 1;
      for (int k = 0; k < L; k++) begin
         ak = 7'(int'(a) + k);
         expa0.push_back(ak); expa1.push_back(ak);
         expd0.push_back({k == L - 1, mem[ak]}); expd1.push_back({k == L - 1, mem[ak]});
      end
      for (int i = 0; i < 2; i++) begin
         done_exp[i]++;
         en_pend[i] = (L > 0); val_pend[i] = (L > 0); pop_pend[i] = (L > 0);
         if (L == 0) done_due[i] = hs_cyc;
      end
      @(posedge rd_clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      while (!(expd0.size() == 0 && expd1.size() == 0 && done_exp[0] == 0 && done_exp[1] == 0 &&
               cmd_ready_w[0] && cmd_ready_w[1]) && w < LIMIT) begin
         @(negedge rd_clk);
         w++;
      end
      chk_le("completion_wait", 0, w, LIMIT - 1);
   endtask

   initial begin : rdy_drv
      @(posedge rd_rst_n);
      forever begin
         @(posedge rd_clk); #1;
         m_ready = rand_rdy ? ($urandom_range(0, 99) < 50) : 1'b1;
      end
   end

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int w;
      for (int i = 0; i < 128; i++) mem[i] = 8'(i);
      repeat (3) @(negedge rd_clk);
      for (int i = 0; i < 2; i++) begin
         chk("rst_cmd_ready", i, 32'(cmd_ready_w[i]), 32'd0);
         chk("rst_rd_en", i, 32'(ram_rd_en_w[i]), 32'd0);
         chk("rst_rd_addr", i, 32'(ram_rd_addr_w[i]), 32'd0);
         chk("rst_m_valid", i, 32'(m_valid_w[i]), 32'd0);
         chk("rst_m_data", i, 32'({m_last_w[i], m_data_w[i]}), 32'd0);
         chk("rst_done", i, 32'(done_w[i]), 32'd0);
         chk("rst_busy", i, 32'(busy_w[i]), 32'd0);
      end
      @(posedge rd_clk); #1;
      rd_rst_n = 1'b1;
      @(negedge rd_clk);
      for (int i = 0; i < 2; i++) chk("cmd_ready_before_edge", i, 32'(cmd_ready_w[i]), 32'd0);
      @(negedge rd_clk);
      for (int i = 0; i < 2; i++) chk("cmd_ready_after_edge", i, 32'(cmd_ready_w[i]), 32'd1);
      mon_en = 1;

      issue(7'h10, 8'd4, 1'b1);  wait_idle();
      issue(7'h7E, 8'd4, 1'b1);  wait_idle();
      rand_rdy = 1;
      issue(7'h20, 8'd16, 1'b0); wait_idle();
      rand_rdy = 0;
      issue(7'h33, 8'd0, 1'b1);  wait_idle();
      repeat (4) @(negedge rd_clk);

      beats[0] = 0;
      issue(7'h05, 8'd20, 1'b1);
      w = 0;
      while (beats[0] < 5 && w < LIMIT) begin
         @(negedge rd_clk);
         w++;
      end
      chk_le("beat5_wait", 0, w, LIMIT - 1);
      @(posedge rd_clk); #1; flush = 1'b1;
      @(posedge rd_clk); #1; flush = 1'b0;
      repeat (8) @(negedge rd_clk);
      for (int i = 0; i < 2; i++) chk("busy_after_flush", i, 32'(busy_w[i]), 32'd0);
      issue(7'h40, 8'd2, 1'b1);  wait_idle();

      @(posedge rd_clk); #1;
      cmd_valid = 1'b1; flush = 1'b1; cmd_addr = 7'h11; cmd_len = 8'd3;
      @(posedge rd_clk); #1;
      cmd_valid = 1'b0; flush = 1'b0;
      repeat (4) @(negedge rd_clk);
      for (int i = 0; i < 2; i++) chk("busy_cmd_with_flush", i, 32'(busy_w[i]), 32'd0);

      issue(7'h50, 8'd128, 1'b1); wait_idle();
      rand_rdy = 1;
      issue(7'h60, 8'd200, 1'b0); wait_idle();
      for (int n = 0; n < 12; n++) issue(7'($urandom_range(0, 127)), 8'($urandom_range(0, 40)), 1'b0);
      wait_idle();
      repeat (5) @(negedge rd_clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
